// File: rtl/round_div_pkg.sv
// round_div_pkg
// Shared types for the round_div_pipe slice.
//   rnd_mode_e  : rounding mode carried with each sample
//   SAT_CNT_W   : width of the optional saturation event counter
//   decode_mode : maps the 2-bit in_mode encoding onto rnd_mode_e
//                 (the unused code 2'b11 behaves as round-half-up)
package round_div_pkg;

  localparam int SAT_CNT_W = 16;

  typedef enum logic [1:0] {
    RND_HALF_UP   = 2'b00,
    RND_TRUNC     = 2'b01,
    RND_HALF_EVEN = 2'b10
  } rnd_mode_e;

  function automatic rnd_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return RND_TRUNC;
      2'b10:   return RND_HALF_EVEN;
      default: return RND_HALF_UP;
    endcase
  endfunction

endpackage

// File: rtl/round_div_round.sv
// round_div_round
// Combinational rounding and saturation for the second pipeline stage.
// Ports:
//   q        in  IN_WIDTH      truncated quotient (dividend >> k_eff)
//   rem      in  MAX_DIV_LOG2  discarded low bits of the dividend
//   half     in  MAX_DIV_LOG2  2^(k_eff-1), zero when k_eff == 0
//   mode     in  rnd_mode_e    rounding mode
//   k_eff    in  SHW           effective exponent
//   out_data out OUT_WIDTH     rounded, saturated quotient
//   out_sat  out 1             result was clamped to all ones
module round_div_round
  import round_div_pkg::*;
#(
  parameter int OUT_WIDTH    = 32,
  parameter int MAX_DIV_LOG2 = 8,
  parameter int IN_WIDTH     = OUT_WIDTH + MAX_DIV_LOG2,
  parameter int SHW          = $clog2(MAX_DIV_LOG2 + 1)
) (
  input  logic [IN_WIDTH-1:0]     q,
  input  logic [MAX_DIV_LOG2-1:0] rem,
  input  logic [MAX_DIV_LOG2-1:0] half,
  input  rnd_mode_e               mode,
  input  logic [SHW-1:0]          k_eff,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic                    out_sat
);

  logic              inc;
  logic [IN_WIDTH:0] r;

  always_comb begin
    inc = 1'b0;
    if (k_eff != '0) begin
      case (mode)
        RND_HALF_UP:   inc = (rem >= half);
        RND_HALF_EVEN: inc = (rem > half) || ((rem == half) && q[0]);
        default:       inc = 1'b0;
      endcase
    end
  end

  // One extra bit so q = all-ones plus a round-up cannot wrap to zero.
  assign r = {1'b0, q} + {{IN_WIDTH{1'b0}}, inc};

  // Any set bit at or above OUT_WIDTH means r exceeds 2^OUT_WIDTH-1;
  // r equal to the maximum passes through unclamped.
  always_comb begin
    out_sat  = |r[IN_WIDTH:OUT_WIDTH];
    out_data = out_sat ? {OUT_WIDTH{1'b1}} : r[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/round_div_pipe.sv
// round_div_pipe
// Two-stage elastic unsigned divide-by-2^k with per-sample rounding mode and
// output saturation. Stage 1 registers the split dividend (quotient,
// remainder, half point); stage 2 registers the rounded, clamped result.
// Optional feature macro: ROUND_DIV_STATS_EN adds the sat_count port.
// Ports:
//   clk, resetn               clock, asynchronous active-low reset
//   in_valid/in_ready         input handshake
//   in_data                   unsigned dividend
//   in_div_log2               exponent k (clamped to MAX_DIV_LOG2)
//   in_mode                   00 half-up, 01 truncate, 10 half-even, 11 half-up
//   out_valid/out_ready       output handshake
//   out_data, out_sat         result and clamp flag
//   sat_count                 saturating count of emitted clamped results
//                             (ROUND_DIV_STATS_EN only)
//
// Handshake: a sample moves across a port on any rising edge where valid and
// ready are both high. valid never depends on ready; once out_valid is high,
// out_valid/out_data/out_sat hold until the transfer. in_ready depends only on
// pipeline occupancy and out_ready, never on in_valid.
module round_div_pipe
  import round_div_pkg::*;
#(
  parameter int   OUT_WIDTH    = 32,
  parameter int   MAX_DIV_LOG2 = 8,
  parameter int   IN_WIDTH     = OUT_WIDTH + MAX_DIV_LOG2,
  localparam int  SHW          = $clog2(MAX_DIV_LOG2 + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [SHW-1:0]       in_div_log2,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sat
`ifdef ROUND_DIV_STATS_EN
  ,
  output logic [SAT_CNT_W-1:0] sat_count
`endif
);

  localparam int             PW    = MAX_DIV_LOG2 + 1;
  localparam logic [SHW-1:0] K_MAX = SHW'(MAX_DIV_LOG2);

  // Stage 1 state
  logic                    v1;
  logic [IN_WIDTH-1:0]     s1_q;
  logic [MAX_DIV_LOG2-1:0] s1_rem;
  logic [MAX_DIV_LOG2-1:0] s1_half;
  rnd_mode_e               s1_mode;
  logic [SHW-1:0]          s1_k;

  // Stage 2 state (drives the outputs directly)
  logic                    v2;

  logic s1_en, s2_en;

  // Input-side decode
  logic [SHW-1:0]          in_k_eff;
  logic [PW-1:0]           in_pow;
  logic [MAX_DIV_LOG2-1:0] in_mask;

  // Stage 2 combinational result
  logic [OUT_WIDTH-1:0]    rd_data;
  logic                    rd_sat;

  assign s2_en     = !v2 || out_ready;
  assign s1_en     = !v1 || s2_en;
  assign in_ready  = s1_en;
  assign out_valid = v2;

  // in_pow = 2^k_eff. Its upper bits give the half point 2^(k_eff-1) (zero for
  // k_eff == 0); its low bits minus one give the remainder mask (wraps to all
  // ones when k_eff == MAX_DIV_LOG2).
  always_comb begin
    in_k_eff = (in_div_log2 > K_MAX) ? K_MAX : in_div_log2;
    in_pow   = PW'(1) << in_k_eff;
    in_mask  = in_pow[MAX_DIV_LOG2-1:0] - MAX_DIV_LOG2'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v1       <= 1'b0;
      s1_q     <= '0;
      s1_rem   <= '0;
      s1_half  <= '0;
      s1_mode  <= RND_HALF_UP;
      s1_k     <= '0;
      v2       <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      if (s1_en) begin
        v1 <= in_valid;
        if (in_valid) begin
          s1_q    <= in_data >> in_k_eff;
          s1_rem  <= in_data[MAX_DIV_LOG2-1:0] & in_mask;
          s1_half <= in_pow[MAX_DIV_LOG2:1];
          s1_mode <= decode_mode(in_mode);
          s1_k    <= in_k_eff;
        end
      end
      if (s2_en) begin
        v2 <= v1;
        if (v1) begin
          out_data <= rd_data;
          out_sat  <= rd_sat;
        end
      end
    end
  end

  round_div_round #(
    .OUT_WIDTH   (OUT_WIDTH),
    .MAX_DIV_LOG2(MAX_DIV_LOG2),
    .IN_WIDTH    (IN_WIDTH),
    .SHW         (SHW)
  ) u_round (
    .q       (s1_q),
    .rem     (s1_rem),
    .half    (s1_half),
    .mode    (s1_mode),
    .k_eff   (s1_k),
    .out_data(rd_data),
    .out_sat (rd_sat)
  );

`ifdef ROUND_DIV_STATS_EN
  // Counts clamped results as they are handed to the consumer; sticks at max.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sat_count <= '0;
    end else if (v2 && out_ready && out_sat && (sat_count != '1)) begin
      sat_count <= sat_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_round_div_pipe.sv
module tb_round_div_pipe;

  localparam int OW  = 8;
  localparam int MK  = 4;
  localparam int IW  = 12;
  localparam int SHW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic          in_valid, in_ready;
  logic [IW-1:0] in_data;
  logic [SHW-1:0] in_div_log2;
  logic [1:0]    in_mode;
  logic          out_valid, out_ready;
  logic [OW-1:0] out_data;
  logic          out_sat;
`ifdef ROUND_DIV_STATS_EN
  logic [15:0]   sat_count;
`endif

  round_div_pipe #(.OUT_WIDTH(OW), .MAX_DIV_LOG2(MK), .IN_WIDTH(IW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_div_log2(in_div_log2),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat)
`ifdef ROUND_DIV_STATS_EN
    ,
    .sat_count  (sat_count)
`endif
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Returns {sat, data} using plain integer division.
  function automatic logic [OW:0] ref_div(input int din, input int k, input int mode);
    int ke, d, q, rem, r;
    ke  = (k > MK) ? MK : k;
    d   = 1 << ke;
    q   = din / d;
    rem = din % d;
    r   = q;
    if (ke != 0) begin
      if (mode == 1) r = q;
      else if (mode == 2) begin
        if ((2 * rem > d) || ((2 * rem == d) && (q % 2 == 1))) r = q + 1;
      end else begin
        if (2 * rem >= d) r = q + 1;
      end
    end
    if (r > (1 << OW) - 1) return {1'b1, {OW{1'b1}}};
    return {1'b0, OW'(r)};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [OW:0] exp_q[$];
  int          cyc = 0;
  int          n_out = 0;
  int          burst_first = -1;
  int          burst_last  = -1;
  logic        prev_stall = 1'b0;
  logic [OW:0] prev_word;
  logic        saw_in_ready_low = 1'b0;

  // Sampled mid-cycle: what is seen here transfers on the next rising edge.
  always @(negedge clk) begin
    logic [OW:0] e;
    cyc++;
    if (!resetn) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready", {31'b0, in_ready},
            {31'b0, !((exp_q.size() >= 2) && !out_ready)});
      if (prev_stall) begin
        check("stall_valid", {31'b0, out_valid}, 32'd1);
        check("stall_word", {23'b0, out_sat, out_data}, {23'b0, prev_word});
      end
      if (out_valid) begin
        check("out_pending", {31'b0, (exp_q.size() != 0)}, 32'd1);
        if (out_ready && (exp_q.size() != 0)) begin
          e = exp_q.pop_front();
          check("out_word", {23'b0, out_sat, out_data}, {23'b0, e});
          n_out++;
          if (burst_first < 0) burst_first = cyc;
          burst_last = cyc;
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(ref_div(int'(in_data), int'(in_div_log2), int'(in_mode)));
      if (!in_ready) saw_in_ready_low = 1'b1;
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_sat, out_data};
    end
  end

  // ---------------- drivers ----------------
  logic rand_ready = 1'b0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int din, input int k, input int mode);
    int n;
    logic acc;
    in_valid    = 1'b1;
    in_data     = IW'(din);
    in_div_log2 = SHW'(k);
    in_mode     = 2'(mode);
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check("send_accept", {31'b0, acc}, 32'd1);
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int saved, n;
    resetn = 1'b0; in_valid = 1'b0; in_data = '0; in_div_log2 = '0;
    in_mode = '0; out_ready = 1'b1;

    // Model pins from hand arithmetic.
    check("pin_20_k3_hu",   {23'b0, ref_div(20, 3, 0)},   {23'b0, 1'b0, 8'd3});
    check("pin_20_k3_tr",   {23'b0, ref_div(20, 3, 1)},   {23'b0, 1'b0, 8'd2});
    check("pin_20_k3_he",   {23'b0, ref_div(20, 3, 2)},   {23'b0, 1'b0, 8'd2});
    check("pin_28_k3_he",   {23'b0, ref_div(28, 3, 2)},   {23'b0, 1'b0, 8'd4});
    check("pin_4095_k4_hu", {23'b0, ref_div(4095, 4, 0)}, {23'b0, 1'b1, 8'd255});
    check("pin_4095_k4_tr", {23'b0, ref_div(4095, 4, 1)}, {23'b0, 1'b0, 8'd255});
    check("pin_4087_k4_hu", {23'b0, ref_div(4087, 4, 0)}, {23'b0, 1'b0, 8'd255});
    check("pin_4088_k4_hu", {23'b0, ref_div(4088, 4, 0)}, {23'b0, 1'b1, 8'd255});
    check("pin_200_k0",     {23'b0, ref_div(200, 0, 0)},  {23'b0, 1'b0, 8'd200});
    check("pin_300_k0",     {23'b0, ref_div(300, 0, 0)},  {23'b0, 1'b1, 8'd255});
    check("pin_40_k7_hu",   {23'b0, ref_div(40, 7, 0)},   {23'b0, 1'b0, 8'd3});
    check("pin_40_k7_m3",   {23'b0, ref_div(40, 7, 3)},   {23'b0, 1'b0, 8'd3});

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_out_data",  {24'b0, out_data},  32'd0);
    check("rst_out_sat",   {31'b0, out_sat},   32'd0);
`ifdef ROUND_DIV_STATS_EN
    check("rst_sat_count", {16'b0, sat_count}, 32'd0);
`endif
    resetn = 1'b1;
    idle(2);

    // Latency on an empty pipe: edges from the accepting edge to out_valid.
    send(20, 3, 0);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
    check("latency_edges", n, 32'd2);
    check("latency_data", {24'b0, out_data}, 32'd3);
    drain();

    // Directed corner cases.
    send(20, 3, 0);   send(20, 3, 1);   send(20, 3, 2);   send(28, 3, 2);
    send(4095, 4, 0); send(4095, 4, 1); send(4087, 4, 0); send(4088, 4, 0);
    send(200, 0, 0);  send(300, 0, 0);  send(40, 7, 0);   send(40, 7, 3);
    send(24, 4, 2);   send(8, 4, 2);    send(4095, 4, 2); send(0, 2, 0);
    drain();

    // Throughput: 8 back-to-back samples, consumer always ready.
    burst_first = -1;
    for (int i = 0; i < 8; i++)
      send(int'($urandom_range(0, 4095)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    drain();
    check("throughput_span", burst_last - burst_first, 32'd7);

    // Six samples with a three-cycle consumer stall mid-stream.
    saw_in_ready_low = 1'b0;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) send(100 + 37 * i, i % 5, i % 3);
        in_valid = 1'b0;
      end
      begin
        idle(2);
        out_ready = 1'b0;
        idle(3);
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_in_ready_low", {31'b0, saw_in_ready_low}, 32'd1);

    // Reset with two samples in flight.
    out_ready = 1'b0;
    send(4095, 0, 0);
    send(50, 1, 0);
    in_valid = 1'b0;
    saved = n_out;
    resetn = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_out_sat",   {31'b0, out_sat},   32'd0);
    idle(2);
    resetn = 1'b1;
    out_ready = 1'b1;
    idle(10);
    check("midrst_no_output", n_out, saved);
`ifdef ROUND_DIV_STATS_EN
    check("midrst_sat_count", {16'b0, sat_count}, 32'd0);
`endif

`ifdef ROUND_DIV_STATS_EN
    // Three clamped results (one stalled two cycles) plus one unclamped.
    fork
      begin
        send(4095, 4, 0); send(300, 0, 1); send(100, 2, 0); send(4095, 0, 2);
        in_valid = 1'b0;
      end
      begin
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        out_ready = 1'b0;
        idle(2);
        out_ready = 1'b1;
      end
    join
    drain();
    idle(2);
    check("stats_sat_count", {16'b0, sat_count}, 32'd3);
`endif

    // Randomized traffic with random backpressure and input gaps.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int din;
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        idle(1);
      end
      din = ($urandom_range(0, 4) == 0) ? int'($urandom_range(4000, 4095))
                                        : int'($urandom_range(0, 4095));
      send(din, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    end
    in_valid = 1'b0;
    rand_ready = 1'b0;
    idle(1);
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
